// File: rtl/stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_controller
// Purpose  : Start/stop/clear controller for a two-digit stopwatch. Two raw
//            pushbuttons are synchronised and debounced into one-cycle press
//            events. Those events drive a three-state FSM (IDLE / RUNNING /
//            PAUSED). The FSM advances a 0..MAX_COUNT counter on every tick
//            while it is running.
// Ports    : clk_50MHz   - single system clock (rising edge)
//            reset       - synchronous, active-high reset
//            tick        - one-cycle count enable, synchronous to clk_50MHz
//            key_start_n - raw start/stop button, active-low, asynchronous
//            key_clear_n - raw clear button, active-low, asynchronous
//            count       - elapsed count, binary, 0..MAX_COUNT
//            running     - registered, high while in RUNNING
//            wrap        - one-cycle pulse when count rolls MAX_COUNT -> 0
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_COUNT       = 99
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    output logic [7:0] count,
    output logic       running,
    output logic       wrap
);

    localparam int             c_STAB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]     c_MAX       = 8'(MAX_COUNT);

    // Key index 0 = start/stop, 1 = clear
    logic [1:0]                w_key_raw;
    logic [1:0]                r_sync0;
    logic [1:0]                r_sync1;
    logic [1:0]                r_db;
    logic [c_STAB_W-1:0]       r_stab [2];
    logic [1:0]                r_press;

    assign w_key_raw = {key_clear_n, key_start_n};

    // Synchroniser + debouncer per key. The debounced level only follows the
    // synchronised level after it has disagreed for DEBOUNCE_CYCLES straight
    // cycles; a press event is produced only on the debounced 1 -> 0 change.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_sync0 <= 2'b11;
            r_sync1 <= 2'b11;
            r_db    <= 2'b11;
            r_press <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                r_stab[k] <= '0;
            end
        end else begin
            r_sync0 <= w_key_raw;
            r_sync1 <= r_sync0;
            for (int k = 0; k < 2; k++) begin
                r_press[k] <= 1'b0;
                if (r_sync1[k] != r_db[k]) begin
                    if (r_stab[k] == c_STAB_LAST) begin
                        r_db[k]    <= r_sync1[k];
                        r_stab[k]  <= '0;
                        r_press[k] <= ~r_sync1[k];
                    end else begin
                        r_stab[k]  <= r_stab[k] + 1'b1;
                    end
                end else begin
                    r_stab[k] <= '0;
                end
            end
        end
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic       r_running;
    logic       r_wrap;
    logic       w_wrap_nxt;
    logic       w_start_ev;
    logic       w_clear_ev;

    assign w_start_ev = r_press[0];
    assign w_clear_ev = r_press[1];

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 8'd0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_running <= (w_state_nxt == S_RUNNING);
            r_wrap    <= w_wrap_nxt;
        end
    end

    // Clear dominates everything (including a coincident start or tick).
    // The increment is qualified by the current state, so a tick arriving
    // with the start event that leaves RUNNING still counts.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (w_clear_ev) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = 8'd0;
        end else begin
            if (tick && (r_state == S_RUNNING)) begin
                if (r_count >= c_MAX) begin
                    w_count_nxt = 8'd0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + 8'd1;
                end
            end
            if (w_start_ev) begin
                case (r_state)
                    S_IDLE:    w_state_nxt = S_RUNNING;
                    S_RUNNING: w_state_nxt = S_PAUSED;
                    S_PAUSED:  w_state_nxt = S_RUNNING;
                    default:   w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_controller
// Purpose  : Self-checking bench for stopwatch_controller. A behavioural
//            model of the stopwatch is compared with the DUT every cycle.
//            Directed scenarios add literal expectations, and a randomised
//            phase follows them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_controller;

    localparam int DB   = 4;
    localparam int MAXC = 99;

    logic       clk_50MHz   = 1'b0;
    logic       reset       = 1'b1;
    logic       tick        = 1'b0;
    logic       key_start_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [7:0] count;
    logic       running;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    stopwatch_controller #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_COUNT      (MAXC)
    ) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .tick       (tick),
        .key_start_n(key_start_n),
        .key_clear_n(key_clear_n),
        .count      (count),
        .running    (running),
        .wrap       (wrap)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0 = start, 1 = clear) -------
    int m_dly1 [2] = '{1, 1};   // key level one edge ago
    int m_dly2 [2] = '{1, 1};   // key level two edges ago (usable level)
    int m_lvl  [2] = '{1, 1};   // accepted button level
    int m_run  [2] = '{0, 0};   // consecutive cycles of disagreement
    int m_evt  [2] = '{0, 0};   // press event visible to the FSM this cycle
    int m_mode = 0;             // 0 idle, 1 running, 2 paused
    int m_cnt  = 0;
    int m_wrap = 0;

    always @(posedge clk_50MHz) begin
        int keys [2];
        keys[0] = key_start_n;
        keys[1] = key_clear_n;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_dly1[k] = 1; m_dly2[k] = 1; m_lvl[k] = 1;
                m_run[k]  = 0; m_evt[k]  = 0;
            end
            m_mode = 0; m_cnt = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (m_evt[1] != 0) begin
                m_mode = 0;
                m_cnt  = 0;
            end else begin
                if (tick && m_mode == 1) begin
                    m_cnt  = (m_cnt + 1) % (MAXC + 1);
                    m_wrap = (m_cnt == 0) ? 1 : 0;
                end
                if (m_evt[0] != 0) m_mode = (m_mode == 1) ? 2 : 1;
            end
            for (int k = 0; k < 2; k++) begin
                m_evt[k] = 0;
                if (m_dly2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_lvl[k] = m_dly2[k];
                        m_run[k] = 0;
                        m_evt[k] = (m_lvl[k] == 0) ? 1 : 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_dly2[k] = m_dly1[k];
                m_dly1[k] = keys[k];
            end
        end
    end

    always @(posedge clk_50MHz) begin
        #1;
        chk("cyc_count",   int'(count),   m_cnt);
        chk("cyc_running", int'(running), (m_mode == 1) ? 1 : 0);
        chk("cyc_wrap",    int'(wrap),    m_wrap);
    end

    // ---------------- stimulus helpers (drive and sample on negedge) -------
    task automatic step(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        step(n);
        tick = 1'b0;
    endtask

    task automatic press_key(input int idx);
        if (idx == 0) key_start_n = 1'b0; else key_clear_n = 1'b0;
        step(DB + 4);
        if (idx == 0) key_start_n = 1'b1; else key_clear_n = 1'b1;
        step(DB + 4);
    endtask

    initial begin
        int rises;
        logic prev;
        int seg_s, seg_c;

        step(3);
        reset = 1'b0;
        chk("rst_count",   int'(count),   0);
        chk("rst_running", int'(running), 0);
        chk("rst_wrap",    int'(wrap),    0);

        // Clean start press: event latency 2+DB, running one edge later.
        key_start_n = 1'b0;
        step(6);
        chk("s1_run_early", int'(running), 0);
        step(1);
        chk("s1_run_on", int'(running), 1);
        step(10);
        chk("s1_held", int'(running), 1);
        key_start_n = 1'b1;
        step(8);
        ticks(5);
        chk("s1_count5", int'(count), 5);
        chk("s1_model5", m_cnt, 5);

        // Bouncing start key then settle low: one event only.
        press_key(1);
        chk("s2_clear_count", int'(count), 0);
        chk("s2_clear_run",   int'(running), 0);
        rises = 0;
        prev  = running;
        for (int i = 0; i < 20; i++) begin
            key_start_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
            if (running && !prev) rises++;
            prev = running;
        end
        key_start_n = 1'b0;
        for (int i = 0; i < 28; i++) begin
            if (i == 20) key_start_n = 1'b1;
            step(1);
            if (running && !prev) rises++;
            prev = running;
        end
        chk("s2_rises", rises, 1);
        chk("s2_running", int'(running), 1);

        // Wrap at MAX_COUNT.
        ticks(98);
        chk("s3_count98", int'(count), 98);
        tick = 1'b1;
        step(1);
        chk("s3_count99", int'(count), 99);
        chk("s3_nowrap",  int'(wrap), 0);
        step(1);
        tick = 1'b0;
        chk("s3_count0", int'(count), 0);
        chk("s3_wrap",   int'(wrap), 1);
        chk("s3_run",    int'(running), 1);
        step(1);
        chk("s3_wrap_gone", int'(wrap), 0);

        // Pause / resume.
        ticks(42);
        chk("s4_count42", int'(count), 42);
        press_key(0);
        chk("s4_paused", int'(running), 0);
        ticks(3);
        chk("s4_hold42", int'(count), 42);
        press_key(0);
        chk("s4_resumed", int'(running), 1);
        ticks(1);
        chk("s4_count43", int'(count), 43);

        // Simultaneous start and clear while running.
        press_key(1);
        press_key(0);
        ticks(17);
        chk("s5_count17", int'(count), 17);
        key_start_n = 1'b0;
        key_clear_n = 1'b0;
        step(7);
        chk("s5_count0", int'(count), 0);
        chk("s5_run0",   int'(running), 0);
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        step(8);
        chk("s5_still_idle", int'(running), 0);

        // Reset mid-count with tick and start key held low through reset.
        press_key(0);
        ticks(30);
        chk("s6_count30", int'(count), 30);
        reset = 1'b1;
        tick = 1'b1;
        key_start_n = 1'b0;
        step(1);
        chk("s6_count0", int'(count), 0);
        chk("s6_run0",   int'(running), 0);
        chk("s6_wrap0",  int'(wrap), 0);
        reset = 1'b0;
        tick = 1'b0;
        step(6);
        chk("s6_run_wait", int'(running), 0);
        step(1);
        chk("s6_run_on", int'(running), 1);
        key_start_n = 1'b1;
        step(8);

        // Randomised phase; the per-cycle compare carries the checking.
        seg_s = 0;
        seg_c = 0;
        for (int i = 0; i < 4000; i++) begin
            tick  = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 599) == 0);
            if (seg_s == 0) begin
                key_start_n = $urandom_range(0, 1) ? 1'b1 : 1'b0;
                seg_s = $urandom_range(1, 12);
            end
            if (seg_c == 0) begin
                key_clear_n = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
                seg_c = $urandom_range(1, 12);
            end
            seg_s--;
            seg_c--;
            step(1);
        end
        reset = 1'b0;
        tick  = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001: The parameter DEBOUNCE_CYCLES SHALL default to 1000000 and set the stable-level cycles a button needs before acceptance, which is 20 ms at 50 MHz.
REQ-002: The parameter MAX_COUNT SHALL default to 99 and set the terminal count value, with legal range 1..255.
REQ-003: Port clk_50MHz SHALL be an input, 1 bit wide, and be the single system clock.
REQ-004: Port reset SHALL be an input, 1 bit wide, synchronous, active-high.
REQ-005: Port tick SHALL be an input, 1 bit wide: a one-cycle count-enable pulse from the slow-clock generator, already synchronous to clk_50MHz.
REQ-006: Port key_start_n SHALL be an input, 1 bit wide: raw asynchronous start/stop pushbutton, active-low.
REQ-007: Port key_clear_n SHALL be an input, 1 bit wide: raw asynchronous clear pushbutton, active-low.
REQ-008: Port count SHALL be an output, 8 bits wide: the current elapsed count, 0..MAX_COUNT, binary, for the BCD encoder.
REQ-009: Port running SHALL be an output, 1 bit wide, high while the FSM is in RUNNING.
REQ-010: Port wrap SHALL be an output, 1 bit wide: a one-cycle pulse when count rolls from MAX_COUNT to 0.

Function
REQ-011: Each key input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012: Each debouncer SHALL update its debounced level only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce back SHALL restart the stability counter at 0.
REQ-013: Each debouncer SHALL emit a one-cycle press event on the debounced high-to-low transition (button pressed) only, never on release.
REQ-014: Press-event latency SHALL be 2 + DEBOUNCE_CYCLES cycles, ±1, from a clean key edge.
REQ-015: A held button SHALL generate exactly one press event.
REQ-016: The FSM SHALL have three states: IDLE (count = 0, stopped), RUNNING, and PAUSED.
REQ-017: A start event in IDLE SHALL move the FSM to RUNNING.
REQ-018: A start event in RUNNING SHALL move the FSM to PAUSED.
REQ-019: A start event in PAUSED SHALL move the FSM to RUNNING.
REQ-020: A clear event in any state SHALL force count = 0 and state IDLE on the next cycle.
REQ-021: Simultaneous clear and start events SHALL be handled as clear; the start event is discarded.
REQ-022: count SHALL increment by 1 on a cycle where tick = 1 and the state is RUNNING, and SHALL hold otherwise.
REQ-023: A tick on the same cycle as the start event that leaves RUNNING SHALL be honoured, because the increment is decided by the pre-transition state.
REQ-024: A tick on the same cycle as a clear event SHALL be discarded, and count SHALL become 0.
REQ-025: At count = MAX_COUNT, a qualifying tick SHALL load 0 and assert wrap for exactly that one cycle, and the state SHALL remain RUNNING.
REQ-026: count SHALL never exceed MAX_COUNT.
REQ-027: running SHALL be a registered output that reflects the state after the transition, with no combinational path from the inputs.
REQ-028: All logic SHALL be clocked on the rising edge of clk_50MHz only; no derived clocks SHALL be used.

Reset
REQ-029: While reset = 1 at a clock edge, the following SHALL hold:
- count = 0, running = 0, wrap = 0, state = IDLE.
- Debounced levels = released (1), stability counters = 0, synchronizer flops = 1.
REQ-030: Reset SHALL take priority over tick and key events on the same edge.
REQ-031: Reset asserted mid-count SHALL abort the operation with no wrap pulse.
REQ-032: On the first cycle after reset deassertion, a key held low SHALL NOT produce a press event until the full debounce period has elapsed.

Verification (sim with DEBOUNCE_CYCLES = 4, MAX_COUNT = 99)
REQ-033: Reset, then a clean press of key_start_n -> running = 1 within 6..7 cycles; then 5 ticks -> count = 5.
REQ-034: key_start_n toggles every 2 cycles for 20 cycles, then settles low -> exactly one start event, running = 1 once only.
REQ-035: Running at count = 98, apply 2 ticks -> count = 99, then 0 with wrap = 1 for exactly 1 cycle; running stays 1.
REQ-036: Running at count = 42, press start -> PAUSED, running = 0; then 3 ticks -> count stays 42; press start -> RUNNING, next tick -> count = 43.
REQ-037: Press start and clear with the same edge while running at count = 17 -> count = 0, running = 0, state IDLE.
REQ-038: Running at count = 30, assert reset for 1 cycle coincident with a tick -> count = 0, running = 0, wrap = 0; with key_start_n held low through reset, running stays 0 until 6 cycles after deassertion.
